// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; kept at least one bit so a 1-bit operand still gets a counter.
    function automatic int unsigned index_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: difference and borrow-out from a_i - b_i - borrow-in.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp negative results (a < b) to zero.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             busy
);

    localparam int unsigned    IW   = index_width(WIDTH);
    localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [IW-1:0]    idx;
    logic             d_c;
    logic             br_c;

    serial_sub_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .br_in  (br),
        .d      (d_c),
        .br_out (br_c)
    );

    // Control FSM, operand shifters, borrow flop and result shifter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            idx       <= '0;
            diff      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        br       <= 1'b0;
                        idx      <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_sr              <= a_sr >> 1;
                    b_sr              <= b_sr >> 1;
                    br                <= br_c;
                    idx               <= idx + IW'(1);
                    diff[WIDTH-1:0]   <= {d_c, diff[WIDTH-1:1]};
                    if (idx == LAST) begin
                        diff[WIDTH] <= br_c;
`ifdef SERIAL_SUB_SAT_EN
                        if (br_c) begin
                            diff <= '0;
                        end
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); honours SERIAL_SUB_SAT_EN for expected values.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] diff;
    logic       busy;

    int vectors = 0;
    int misses  = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected value for a hand-computed two's-complement result under the build's clamp option.
    function automatic logic [4:0] sat(input logic [4:0] e);
`ifdef SERIAL_SUB_SAT_EN
        return e[4] ? 5'b00000 : e;
`else
        return e;
`endif
    endfunction

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [4:0] e, input string tag);
        int lat;
        check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_v;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " diff"}, 32'(diff), 32'(e));
        check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        check({tag, " busy in DONE"}, 32'(busy), 32'd1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
        check({tag, " busy after hs"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] pair;
        logic [4:0] e;
        int         last_rise;
        int         n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(4'd5, 4'd3, 5'b00010, "5-3");
        handshake("5-3");
        run_op(4'd3, 4'd5, sat(5'b11110), "3-5");
        handshake("3-5");
        run_op(4'd15, 4'd0, 5'b01111, "15-0");
        handshake("15-0");
        run_op(4'd0, 4'd15, sat(5'b10001), "0-15");
        handshake("0-15");
        run_op(4'd0, 4'd0, 5'b00000, "0-0");
        handshake("0-0");

        // Consumer stalls three cycles; a stray in_valid pulse must be ignored.
        run_op(4'd12, 4'd7, 5'b00101, "stall");
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                a = 4'd1;
                b = 4'd2;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            check("stall diff", 32'(diff), 32'b00101);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        handshake("stall");
        run_op(4'd6, 4'd10, sat(5'b11100), "post-stall");
        handshake("post-stall");

        // Abort mid-calculation, then reset coinciding with in_valid.
        a = 4'd7;
        b = 4'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        a = 4'd3;
        b = 4'd1;
        in_valid = 1'b1;
        step();
        check("rst+valid busy", 32'(busy), 32'd0);
        check("rst+valid in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        check("idle after rst busy", 32'(busy), 32'd0);
        run_op(4'd9, 4'd4, 5'b00101, "9-4");
        handshake("9-4");

        // Back-to-back with both handshakes held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 4'($urandom);
        b = 4'($urandom);
        last_rise = -1;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
            if (in_ready) q.push_back({a, b});
            step();
            if (out_valid) begin
                if (q.size() > 0) begin
                    pair = q.pop_front();
                    e = 5'(pair[7:4]) - 5'(pair[3:0]);
                    e = sat(e);
                    check("b2b diff", 32'(diff), 32'(e));
                end else begin
                    check("b2b spurious result", 32'(out_valid), 32'd0);
                end
                if (last_rise >= 0) check("b2b interval", 32'(cyc - last_rise), 32'd6);
                last_rise = cyc;
                n++;
            end
            a = 4'($urandom);
            b = 4'($urandom);
        end
        check("b2b result count", 32'(n), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
